systolic_mm_sequencer: RTL
==========================

Name: systolic_mm_sequencer

Overview:
Controller for the 8x8 signed-8-bit systolic multiply array and its input/output RAMs. On a start request it clears the PE accumulators and issues skewed per-lane reads of A (rows) and B (columns) so operands enter the array diagonally. It then waits for the array to flush, and drains all 64 results into the C RAM in row-major order. It reports busy/done and a cycle count, replacing free-running index logic with an explicit FSM.

Parameters:
N, 8, array dimension (lanes per side)
AW, 6, A/B/C RAM address width (log2(N*N))
CW, 11, cycle counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  run request; sampled only in IDLE
busy  out  1  high from CLEAR through DONE inclusive
done  out  1  one-cycle pulse in DONE state
pe_clr  out  1  synchronous accumulator clear to all PEs (CLEAR state)
a_ren  out  N  per-row A read enable, lane r = bit r
a_addr  out  N*AW  per-row A address, lane r = bits [r*AW +: AW]
b_ren  out  N  per-column B read enable
b_addr  out  N*AW  per-column B address
a_zero  out  N  a_ren delayed 1 cycle and inverted; PE west inputs forced to 0 where set
b_zero  out  N  same for B/north inputs
c_we  out  1  C RAM write enable
c_addr  out  AW  C RAM address, also the PE result select (row*N+col)
cycles  out  CW  cycles of last completed run, held until next done

Behaviour:
- Reset (async): state=IDLE. All outputs 0, including a_zero/b_zero (all-ones zero masks not required in IDLE). Counters 0, cycles=0. Reset mid-run abandons the run immediately; c_we drops with rst.
- FSM: IDLE -> CLEAR -> FEED -> FLUSH -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 -> CLEAR next edge. start in any other state is ignored (not queued).
- CLEAR: 1 cycle, pe_clr=1.
- FEED: step t = 0..2N-2 (15 cycles), t incremented each cycle.
  - Row lane r: a_ren[r]=1 iff r <= t <= r+N-1; a_addr lane r = r*N + (t-r), else 0.
  - Column lane c: b_ren[c]=1 iff c <= t <= c+N-1; b_addr lane c = (t-c)*N + c, else 0.
  - A and B are stored row-major.
- RAM read latency is 1 cycle, so a_zero/b_zero are registered copies of ~a_ren/~b_ren, aligned with read data. During CLEAR and FLUSH both masks are all-ones.
- FLUSH: N+1 cycles (9) for the last operands to reach PE(N-1,N-1) and accumulate.
- DRAIN: N*N cycles. c_we=1, c_addr = 0..63 incrementing. Result width 19 bits signed, no saturation. Last write at c_addr=63, then DONE.
- DONE: done=1 for 1 cycle, busy still 1. cycles latched = cycles elapsed from the first CLEAR cycle to the DONE cycle inclusive: 1+15+9+64+1 = 90 for N=8.
- Back-to-back: start held high gives exactly one IDLE cycle between runs.
- No wrap: step, flush and drain counters each reset to 0 on state entry.
- c_addr holds 0 outside DRAIN.
- Run counter saturates at 2^CW-1.

Test Plan:
- Reset then start pulse -> pe_clr high exactly 1 cycle. FEED 15 cycles. First c_we 25 cycles after CLEAR. done at cycle 90. cycles=90, busy low the next cycle.
- FEED address check: at t=3 -> a_ren=8'b00001111, lane 2 a_addr=17, b lane 2 b_addr=10, lane 5 enables 0. Next cycle a_zero=8'b11110000.
- Full datapath, A=identity and B[i][j]=i*8+j -> C RAM row-major equals B. A=all 1, B=all 1 -> all 64 C entries = 8.
- Extremes: A=all -128, B=all -128 -> every C = 131072, no overflow in 19 bits.
- Assert rst during FEED at t=7 -> all outputs 0 immediately, no C write. A new start after release completes a correct full run.
- start held high for 200 cycles -> two complete runs, done pulses 91 cycles apart. start pulses during busy -> no effect.

Source files
------------

// File: rtl/systolic_mm_sequencer.sv
// Sequencer for an NxN systolic multiply array: clears PEs, feeds skewed A/B
// reads, waits for the wavefront to flush, then drains results to C RAM.
module systolic_mm_sequencer #(
  parameter int N  = 8,
  parameter int AW = 6,
  parameter int CW = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            pe_clr,
  output logic [N-1:0]    a_ren,
  output logic [N*AW-1:0] a_addr,
  output logic [N-1:0]    b_ren,
  output logic [N*AW-1:0] b_addr,
  output logic [N-1:0]    a_zero,
  output logic [N-1:0]    b_zero,
  output logic            c_we,
  output logic [AW-1:0]   c_addr,
  output logic [CW-1:0]   cycles
);

  localparam int FEED_LEN  = 2*N - 1;
  localparam int FLUSH_LEN = N + 1;
  localparam int DRAIN_LEN = N * N;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt;
  logic          cnt_last;
  logic [CW-1:0] run_cnt;

  // State register; the shared step/flush/drain counter restarts on every state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
      if (state_nxt != state || state == S_IDLE) cnt <= '0;
      else                                       cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves a latch behind.
    cnt_last = 1'b0;
    case (state)
      S_FEED:  cnt_last = (cnt == AW'(FEED_LEN - 1));
      S_FLUSH: cnt_last = (cnt == AW'(FLUSH_LEN - 1));
      S_DRAIN: cnt_last = (cnt == AW'(DRAIN_LEN - 1));
      default: cnt_last = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_FEED;
      S_FEED:  if (cnt_last) state_nxt = S_FLUSH;
      S_FLUSH: if (cnt_last) state_nxt = S_DRAIN;
      S_DRAIN: if (cnt_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lane k is live for steps k..k+N-1, which skews operands onto the diagonal.
  always_comb begin
    busy   = (state != S_IDLE);
    done   = (state == S_DONE);
    pe_clr = (state == S_CLEAR);
    c_we   = (state == S_DRAIN);
    c_addr = (state == S_DRAIN) ? cnt : '0;
    a_ren  = '0;
    b_ren  = '0;
    a_addr = '0;
    b_addr = '0;
    if (state == S_FEED) begin
      for (int k = 0; k < N; k++) begin
        if (int'(cnt) >= k && int'(cnt) <= k + N - 1) begin
          a_ren[k]            = 1'b1;
          b_ren[k]            = 1'b1;
          a_addr[k*AW +: AW]  = AW'(k*N + int'(cnt) - k);
          b_addr[k*AW +: AW]  = AW'((int'(cnt) - k)*N + k);
        end
      end
    end
  end

  // Masks line up with the one-cycle RAM read data; cleared when returning to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_zero <= '0;
      b_zero <= '0;
    end else if (state_nxt == S_IDLE) begin
      a_zero <= '0;
      b_zero <= '0;
    end else begin
      a_zero <= ~a_ren;
      b_zero <= ~b_ren;
    end
  end

  // run_cnt is 1 in CLEAR, so the DONE-cycle value spans CLEAR..DONE inclusive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt <= '0;
      cycles  <= '0;
    end else begin
      if (state == S_IDLE) begin
        if (start) run_cnt <= CW'(1);
      end else if (run_cnt != '1) begin
        run_cnt <= run_cnt + 1'b1;
      end
      if (state == S_DONE) cycles <= run_cnt;
    end
  end

endmodule
